// File: rtl/mem_stream_sequencer.sv
// rtl/mem_stream_sequencer.sv - N-channel stepped memory address sequencer
// Optional feature macro SEQ_WRAP_EN: wrap to address 0 at end of memory instead of flagging err.
module mem_stream_sequencer #(
    parameter int              NCH    = 2,
    parameter int              AW     = 16,
    parameter int              DW     = 8,
    parameter logic [DW-1:0]   TERM   = 8'hFF,
    parameter int              RD_LAT = 1
) (
    input  logic                clk2,
    input  logic                rst,
    input  logic [NCH-1:0]      start,
    input  logic [NCH-1:0]      step,
    input  logic [NCH*DW-1:0]   data,
    output logic [NCH*AW-1:0]   addr,
    output logic [NCH-1:0]      cs,
    output logic [NCH-1:0]      en,
    output logic [NCH-1:0]      valid,
    output logic [NCH-1:0]      done,
    output logic [NCH-1:0]      err,
    output logic                busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_VALID = 2'd3;

    // WAIT counts down from RD_LAT-1 so the read data is settled when CHECK samples it
    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [1:0]    state_q, state_d;
        logic [1:0]    cnt_q, cnt_d;
        logic [AW-1:0] addr_q, addr_d;
        logic          cs_q, cs_d;
        logic          valid_q, valid_d;
        logic          done_q, done_d;
        logic          err_q, err_d;
        logic [DW-1:0] word;

        assign word = data[k*DW +: DW];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            addr_d  = addr_q;
            cs_d    = cs_q;
            valid_d = valid_q;
            done_d  = 1'b0;
            err_d   = err_q;
            case (state_q)
                S_IDLE: begin
                    if (start[k]) begin
                        addr_d  = '0;
                        cs_d    = 1'b1;
                        err_d   = 1'b0;
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 2'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                S_CHECK: begin
                    if (word == TERM) begin
                        cs_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        valid_d = 1'b1;
                        state_d = S_VALID;
                    end
                end
                S_VALID: begin
                    if (step[k]) begin
                        valid_d = 1'b0;
                        if (addr_q != {AW{1'b1}}) begin
                            addr_d  = addr_q + AW'(1);
                            cnt_d   = CNT_INIT;
                            state_d = S_WAIT;
                        end else begin
`ifdef SEQ_WRAP_EN
                            addr_d  = '0;
                            cnt_d   = CNT_INIT;
                            state_d = S_WAIT;
`else
                            // Ran off the end without a terminator: stop and flag it
                            cs_d    = 1'b0;
                            err_d   = 1'b1;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
`endif
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        always_ff @(posedge clk2 or posedge rst) begin
            if (rst) begin
                state_q <= S_IDLE;
                cnt_q   <= 2'd0;
                addr_q  <= '0;
                cs_q    <= 1'b0;
                valid_q <= 1'b0;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                addr_q  <= addr_d;
                cs_q    <= cs_d;
                valid_q <= valid_d;
                done_q  <= done_d;
                err_q   <= err_d;
            end
        end

        assign addr[k*AW +: AW] = addr_q;
        assign cs[k]            = cs_q;
        assign en[k]            = cs_q;
        assign valid[k]         = valid_q;
        assign done[k]          = done_q;
        assign err[k]           = err_q;
    end

    assign busy = |cs;

endmodule

// File: tb/tb_mem_stream_sequencer.sv
// tb/tb_mem_stream_sequencer.sv - self-checking bench: RD_LAT=1 and RD_LAT=3 instances, AW=3
module tb_mem_stream_sequencer;

    logic       clk2 = 1'b0;
    logic       rst;
    logic [1:0] start_v [2];
    logic [1:0] step_v  [2];
    logic [15:0] data0, data1;
    logic [5:0] addr0, addr1;
    logic [1:0] cs0, cs1, en0, en1, valid0, valid1, done0, done1, err0, err1;
    logic       busy0, busy1;

    logic [7:0] mem  [2][2][8];
    logic [7:0] pipe [2][2][3];

    bit         m_act  [2][2];
    bit         m_vld  [2][2];
    bit         m_done [2][2];
    bit         m_err  [2][2];
    int         m_cnt  [2][2];
    logic [2:0] m_addr [2][2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk2 = ~clk2;

    // Memories with 1 (dut0) and 3 (dut1) cycles of read latency
    always @(posedge clk2) begin
        for (int ch = 0; ch < 2; ch++) begin
            pipe[0][ch][0] <= mem[0][ch][addr0[ch*3 +: 3]];
            pipe[1][ch][0] <= mem[1][ch][addr1[ch*3 +: 3]];
            for (int d = 0; d < 2; d++) begin
                pipe[d][ch][1] <= pipe[d][ch][0];
                pipe[d][ch][2] <= pipe[d][ch][1];
            end
        end
    end
    assign data0 = {pipe[0][1][0], pipe[0][0][0]};
    assign data1 = {pipe[1][1][2], pipe[1][0][2]};

    mem_stream_sequencer #(.NCH(2), .AW(3), .DW(8), .TERM(8'hFF), .RD_LAT(1)) u_dut0 (
        .clk2(clk2), .rst(rst), .start(start_v[0]), .step(step_v[0]), .data(data0),
        .addr(addr0), .cs(cs0), .en(en0), .valid(valid0), .done(done0), .err(err0), .busy(busy0)
    );

    mem_stream_sequencer #(.NCH(2), .AW(3), .DW(8), .TERM(8'hFF), .RD_LAT(3)) u_dut1 (
        .clk2(clk2), .rst(rst), .start(start_v[1]), .step(step_v[1]), .data(data1),
        .addr(addr1), .cs(cs1), .en(en1), .valid(valid1), .done(done1), .err(err1), .busy(busy1)
    );

    // Latency-based reference: a read resolves lat+1 edges after its address is issued
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < 2; ch++) begin
                int lat;
                lat = (d == 0) ? 1 : 3;
                m_done[d][ch] = 1'b0;
                if (!m_act[d][ch]) begin
                    if (start_v[d][ch]) begin
                        m_act[d][ch]  = 1'b1;
                        m_addr[d][ch] = 3'd0;
                        m_err[d][ch]  = 1'b0;
                        m_vld[d][ch]  = 1'b0;
                        m_cnt[d][ch]  = lat + 1;
                    end
                end else if (!m_vld[d][ch]) begin
                    m_cnt[d][ch] = m_cnt[d][ch] - 1;
                    if (m_cnt[d][ch] == 0) begin
                        if (mem[d][ch][m_addr[d][ch]] == 8'hFF) begin
                            m_act[d][ch]  = 1'b0;
                            m_done[d][ch] = 1'b1;
                        end else begin
                            m_vld[d][ch] = 1'b1;
                        end
                    end
                end else if (step_v[d][ch]) begin
                    m_vld[d][ch] = 1'b0;
                    if (m_addr[d][ch] == 3'd7) begin
`ifdef SEQ_WRAP_EN
                        m_addr[d][ch] = 3'd0;
                        m_cnt[d][ch]  = lat + 1;
`else
                        m_act[d][ch]  = 1'b0;
                        m_done[d][ch] = 1'b1;
                        m_err[d][ch]  = 1'b1;
`endif
                    end else begin
                        m_addr[d][ch] = m_addr[d][ch] + 3'd1;
                        m_cnt[d][ch]  = lat + 1;
                    end
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < 2; ch++) begin
                m_act[d][ch] = 0; m_vld[d][ch] = 0; m_done[d][ch] = 0;
                m_err[d][ch] = 0; m_cnt[d][ch] = 0; m_addr[d][ch] = 3'd0;
            end
        end
    endtask

    function automatic logic [16:0] obs_vec(int d);
        if (d == 0) return {busy0, err0, done0, valid0, en0, cs0, addr0};
        return {busy1, err1, done1, valid1, en1, cs1, addr1};
    endfunction

    function automatic logic [16:0] exp_vec(int d);
        logic [5:0] a;
        logic [1:0] c, v, dn, e;
        logic       b;
        b = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            a[ch*3 +: 3] = m_addr[d][ch];
            c[ch]  = m_act[d][ch];
            v[ch]  = m_vld[d][ch];
            dn[ch] = m_done[d][ch];
            e[ch]  = m_err[d][ch];
            b      = b | m_act[d][ch];
        end
        return {b, e, dn, v, c, c, a};
    endfunction

    task automatic tick();
        @(posedge clk2);
        model_step();
        @(negedge clk2);
        cyc++;
        start_v[0] = 2'b00;
        start_v[1] = 2'b00;
    endtask

    task automatic abort_all();
        @(negedge clk2);
        rst = 1'b1;
        model_reset();
        step_v[0] = 2'b00;
        step_v[1] = 2'b00;
        @(negedge clk2);
        rst = 1'b0;
    endtask

    task automatic fill_random(int d, int ch, bit allow_term);
        for (int i = 0; i < 8; i++) begin
            if (allow_term && $urandom_range(0, 5) == 0) mem[d][ch][i] = 8'hFF;
            else mem[d][ch][i] = 8'($urandom_range(0, 254));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_v[0] = 2'b00; start_v[1] = 2'b00;
        step_v[0] = 2'b00;  step_v[1] = 2'b00;
        model_reset();
        for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < 2; ch++) fill_random(d, ch, 1'b0);
        repeat (2) @(negedge clk2);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_vec(d) !== 17'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d got %h expected %h", d, obs_vec(d), 17'd0);
            end
        end
        rst = 1'b0;
        start_v[0] = 2'b11;
        start_v[1] = 2'b11;
        repeat (3) tick();
        // Assert reset mid-cycle, away from any clock edge
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_vec(d) !== 17'd0) begin
                errors++;
                $display("FAIL async_reset dut%0d got %h expected %h", d, obs_vec(d), 17'd0);
            end
        end
        @(negedge clk2);
        rst = 1'b0;
    endtask

    task automatic test_basic_stream();
        int t0, first_v, done_c;
        fill_random(0, 0, 1'b0);
        mem[0][0][0] = 8'h41; mem[0][0][1] = 8'h42; mem[0][0][2] = 8'hFF;
        first_v = -1; done_c = -1;
        t0 = cyc;
        start_v[0] = 2'b01;
        for (int i = 0; i < 12; i++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL basic_stream dut%0d cyc %0d got %h expected %h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
            if (valid0[0] && first_v < 0) first_v = cyc - t0 - 1;
            if (done0[0]) done_c = cyc - t0 - 1;
            step_v[0] = {1'b0, valid0[0]};
        end
        checks++;
        if (first_v !== 2) begin
            errors++;
            $display("FAIL basic_first_valid got %0d expected 2", first_v);
        end
        checks++;
        if (done_c !== 8) begin
            errors++;
            $display("FAIL basic_done_cycle got %0d expected 8", done_c);
        end
        checks++;
        if ({addr0[2:0], err0[0], cs0[0]} !== {3'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_final got addr %0d err %b cs %b expected addr 2 err 0 cs 0", addr0[2:0], err0[0], cs0[0]);
        end
        abort_all();
    endtask

    task automatic test_immediate_term();
        int t0, done1_c;
        bit saw_v1;
        fill_random(0, 0, 1'b0);
        mem[0][0][4] = 8'hFF;
        fill_random(0, 1, 1'b0);
        mem[0][1][0] = 8'hFF;
        saw_v1 = 0; done1_c = -1;
        t0 = cyc;
        start_v[0] = 2'b11;
        for (int i = 0; i < 24; i++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL immediate_term dut%0d cyc %0d got %h expected %h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
            if (valid0[1]) saw_v1 = 1;
            if (done0[1]) done1_c = cyc - t0 - 1;
            step_v[0] = {1'b0, 1'($urandom_range(0, 1))};
        end
        checks++;
        if (saw_v1 !== 1'b0 || done1_c !== 2) begin
            errors++;
            $display("FAIL immediate_term_ch1 got valid_seen %0d done_cycle %0d expected 0 and 2", saw_v1, done1_c);
        end
        abort_all();
    endtask

    task automatic test_backpressure();
        fill_random(0, 0, 1'b0);
        start_v[0] = 2'b01;
        for (int i = 0; i < 13; i++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL backpressure dut%0d cyc %0d got %h expected %h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
            step_v[0] = 2'b00;
            start_v[0] = (i % 2 == 1) ? 2'b01 : 2'b00;
        end
        checks++;
        if ({valid0[0], addr0[2:0]} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL backpressure_hold got valid %b addr %0d expected valid 1 addr 0", valid0[0], addr0[2:0]);
        end
        abort_all();
    endtask

    task automatic test_end_of_memory();
        bit saw_wrap, ended;
        logic [2:0] prev;
        fill_random(0, 0, 1'b0);
        saw_wrap = 0; ended = 0; prev = 3'd0;
        start_v[0] = 2'b01;
        for (int i = 0; i < 40; i++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL end_of_memory dut%0d cyc %0d got %h expected %h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
            if (prev == 3'd7 && addr0[2:0] == 3'd0 && cs0[0]) saw_wrap = 1;
            if (done0[0]) ended = 1;
            prev = addr0[2:0];
            step_v[0] = {1'b0, valid0[0]};
        end
`ifdef SEQ_WRAP_EN
        checks++;
        if ({saw_wrap, ended, err0[0]} !== 3'b100) begin
            errors++;
            $display("FAIL eom_wrap got wrap %b done %b err %b expected 1 0 0", saw_wrap, ended, err0[0]);
        end
`else
        checks++;
        if ({ended, err0[0], cs0[0], addr0[2:0]} !== {1'b1, 1'b1, 1'b0, 3'd7}) begin
            errors++;
            $display("FAIL eom_err got done %b err %b cs %b addr %0d expected 1 1 0 7", ended, err0[0], cs0[0], addr0[2:0]);
        end
`endif
        mem[0][0][0] = 8'hFF;
        step_v[0] = 2'b00;
        start_v[0] = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL eom_restart cyc %0d got %h expected %h", cyc, obs_vec(0), exp_vec(0));
            end
        end
        abort_all();
    endtask

    task automatic test_dual_latency();
        int t0;
        int first_v [2];
        for (int ch = 0; ch < 2; ch++) begin
            fill_random(1, ch, 1'b0);
            mem[1][ch][$urandom_range(1, 7)] = 8'hFF;
            first_v[ch] = -1;
        end
        t0 = cyc;
        start_v[1] = 2'b11;
        for (int i = 0; i < 60; i++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL dual_latency dut%0d cyc %0d got %h expected %h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
            for (int ch = 0; ch < 2; ch++)
                if (valid1[ch] && first_v[ch] < 0) first_v[ch] = cyc - t0 - 1;
            step_v[1] = 2'($urandom_range(0, 3));
        end
        for (int ch = 0; ch < 2; ch++) begin
            checks++;
            if (first_v[ch] !== 4) begin
                errors++;
                $display("FAIL dual_first_valid ch%0d got %0d expected 4", ch, first_v[ch]);
            end
        end
        abort_all();
    endtask

    task automatic test_random();
        for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < 2; ch++) fill_random(d, ch, 1'b1);
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < 2; d++) begin
                start_v[d] = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
                step_v[d]  = 2'($urandom_range(0, 3));
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL random dut%0d cyc %0d got %h expected %h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
        end
        abort_all();
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_immediate_term();
        test_backpressure();
        test_end_of_memory();
        test_dual_latency();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
